add4: RTL and testbench
=======================

ADD4 -- requirements
Module: add4

Interface
REQ-001 Parameters: none; widths fixed at 4 bits.
REQ-002 clk  input  1  sole clock; all registered state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 a  input  4  addend A, unsigned or two's-complement.
REQ-005 b  input  4  addend B.
REQ-006 ci  input  1  carry-in.
REQ-007 s  output  4  combinational sum.
REQ-008 co  output  1  combinational carry-out.
REQ-009 ovf  output  1  combinational signed overflow.
REQ-010 zero  output  1  combinational; high when s == 4'h0.
REQ-011 gp  output  1  combinational group propagate.
REQ-012 gg  output  1  combinational group generate.
REQ-013 en  input  1  capture enable for the registered result.
REQ-014 s_q  output  4  registered sum.
REQ-015 co_q  output  1  registered carry-out.
REQ-016 ovf_q  output  1  registered overflow.
REQ-017 vld_q  output  1  registered valid flag.

Function
REQ-018 {co, s} SHALL equal a + b + ci, computed as a 5-bit unsigned sum, for all 512 input combinations.
REQ-019 Combinational outputs (s, co, ovf, zero, gp, gg) SHALL depend only on a, b and ci, with no dependence on clk, rst or en; outputs settle within one combinational evaluation.
REQ-020 The adder SHALL use carry-lookahead: per-bit g[i] = a[i]&b[i] and p[i] = a[i]^b[i]; carries c1..c4 are formed as sum-of-products of g, p and ci with no rippled carry chain; s[i] = p[i]^c[i], where c0 = ci.
REQ-021 co SHALL equal c4; gp SHALL equal &p; gg SHALL equal g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0.
REQ-022 ovf SHALL equal c4 ^ c3, i.e. the two's-complement overflow of a + b + ci.
REQ-023 On a rising clk edge with rst=0 and en=1, s_q, co_q and ovf_q SHALL capture s, co and ovf; vld_q SHALL become 1.
REQ-024 On a rising clk edge with rst=0 and en=0, s_q, co_q and ovf_q SHALL hold their values; vld_q SHALL become 0.
REQ-025 Registered latency SHALL be exactly one clock from input to s_q.

Reset
REQ-026 On a rising clk edge with rst=1, s_q, co_q, ovf_q and vld_q SHALL all be 0, regardless of en.
REQ-027 rst SHALL NOT affect the combinational outputs.
REQ-028 When rst is asserted mid-stream, it SHALL discard any capture on that edge; capture resumes on the first edge after rst is deasserted.

Verification
REQ-029 Exhaustive sweep of all 512 {a,b,ci} combinations, checked after settling -> {co,s} == a+b+ci for every vector.
REQ-030 Boundary sums:
  - a=0, b=0, ci=0 -> s=0, co=0, zero=1.
  - a=F, b=F, ci=1 -> s=F, co=1, gp=0, gg=1.
  - a=F, b=0, ci=1 -> s=0, co=1, gp=1, zero=1.
REQ-031 Signed overflow: a=7, b=1, ci=0 -> s=8, co=0, ovf=1; a=8, b=8, ci=0 -> s=0, co=1, ovf=1.
REQ-032 Registered path: rst=1 for 2 edges -> all _q outputs 0; then en=1 with a=3, b=4, ci=1 -> s_q=8, vld_q=1 after one edge; then en=0 -> s_q holds 8, vld_q=0.
REQ-033 Reset priority: rst=1 and en=1 on the same edge -> s_q=0, co_q=0, vld_q=0, while s continues to track the inputs combinationally.

Source files
------------

// File: rtl/add4.sv
// 4-bit carry-lookahead adder with flag outputs and an enable-gated result register.
// Sum and flags are purely combinational; the registered copy has one cycle of latency.
module add4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    input  logic       en,
    output logic [3:0] s,
    output logic       co,
    output logic       ovf,
    output logic       zero,
    output logic       gp,
    output logic       gg,
    output logic [3:0] s_q,
    output logic       co_q,
    output logic       ovf_q,
    output logic       vld_q
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum-of-products of g, p and ci; no carry feeds another.
    always_comb begin
        c[0] = ci;
        c[1] = g[0]
             | (p[0] & ci);
        c[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & ci);
        c[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
    end

    assign s    = p ^ c[3:0];
    assign co   = c[4];
    assign ovf  = c[4] ^ c[3];
    assign zero = (s == 4'h0);
    assign gp   = &p;
    assign gg   = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);

    // Reset wins over enable; vld_q flags only the edge that actually captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q   <= 4'h0;
            co_q  <= 1'b0;
            ovf_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            if (en) begin
                s_q   <= s;
                co_q  <= co;
                ovf_q <= ovf;
            end
            vld_q <= en;
        end
    end

endmodule

// File: tb/tb_add4.sv
// Self-checking bench for add4: exhaustive and directed combinational checks plus
// randomized registered-path checks against an arithmetic reference model.
module tb_add4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic       en;
    logic [3:0] s;
    logic       co;
    logic       ovf;
    logic       zero;
    logic       gp;
    logic       gg;
    logic [3:0] s_q;
    logic       co_q;
    logic       ovf_q;
    logic       vld_q;

    int checks   = 0;
    int failures = 0;

    // Expected registered state, advanced by the bench on each rising edge.
    logic [3:0] m_s_q;
    logic       m_co_q;
    logic       m_ovf_q;
    logic       m_vld_q;

    add4 dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .en    (en),
        .s     (s),
        .co    (co),
        .ovf   (ovf),
        .zero  (zero),
        .gp    (gp),
        .gg    (gg),
        .s_q   (s_q),
        .co_q  (co_q),
        .ovf_q (ovf_q),
        .vld_q (vld_q)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, returns {gg, gp, zero, ovf, co, s[3:0]}.
    function automatic logic [8:0] ref_model(input logic [3:0] ra, input logic [3:0] rb,
                                             input logic rci);
        int unsigned usum;
        int          ssum;
        logic [3:0]  rs;
        logic        rco, rovf, rzero, rgp, rgg;
        usum  = int'(ra) + int'(rb) + int'(rci);
        ssum  = int'($signed(ra)) + int'($signed(rb)) + int'(rci);
        rs    = usum[3:0];
        rco   = (usum >= 16);
        rovf  = (ssum > 7) || (ssum < -8);
        rzero = (rs == 4'h0);
        rgp   = ((int'(ra) + int'(rb)) == 15);
        rgg   = ((int'(ra) + int'(rb)) >= 16);
        return {rgg, rgp, rzero, rovf, rco, rs};
    endfunction

    function automatic void model_edge();
        logic [8:0] r;
        r = ref_model(a, b, ci);
        if (rst) begin
            m_s_q = 4'h0; m_co_q = 1'b0; m_ovf_q = 1'b0; m_vld_q = 1'b0;
        end else begin
            if (en) begin
                m_s_q = r[3:0]; m_co_q = r[4]; m_ovf_q = r[5];
            end
            m_vld_q = en;
        end
    endfunction

    task automatic drive(input logic [3:0] ta, input logic [3:0] tb, input logic tci,
                         input logic ten, input logic trst);
        a = ta; b = tb; ci = tci; en = ten; rst = trst;
    endtask

    // One clock: drive away from the edge, update the model at the edge, settle.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        drive(4'h5, 4'h6, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        checks++;
        if ({s_q, co_q, ovf_q, vld_q} !== 7'b0) begin
            failures++;
            $display("FAIL reset_regs got=%b exp=%b", {s_q, co_q, ovf_q, vld_q}, 7'b0);
        end
        checks++;
        if (s !== 4'hC) begin
            failures++;
            $display("FAIL reset_comb_s got=%h exp=%h", s, 4'hC);
        end
    endtask

    task automatic test_exhaustive();
        logic [8:0] r;
        for (int i = 0; i < 512; i++) begin
            a = i[3:0]; b = i[7:4]; ci = i[8];
            #1;
            r = ref_model(a, b, ci);
            checks++;
            if ({gg, gp, zero, ovf, co, s} !== r) begin
                failures++;
                $display("FAIL exhaustive a=%h b=%h ci=%b got=%b exp=%b",
                         a, b, ci, {gg, gp, zero, ovf, co, s}, r);
            end
        end
    endtask

    task automatic test_boundary();
        a = 4'h0; b = 4'h0; ci = 1'b0; #1;
        checks++;
        if ({s, co, zero} !== {4'h0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL bound_zero got s=%h co=%b zero=%b exp s=0 co=0 zero=1", s, co, zero);
        end
        a = 4'hF; b = 4'hF; ci = 1'b1; #1;
        checks++;
        if ({s, co, gp, gg} !== {4'hF, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL bound_ff1 got s=%h co=%b gp=%b gg=%b exp s=f co=1 gp=0 gg=1",
                     s, co, gp, gg);
        end
        a = 4'hF; b = 4'h0; ci = 1'b1; #1;
        checks++;
        if ({s, co, gp, zero} !== {4'h0, 1'b1, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL bound_f01 got s=%h co=%b gp=%b zero=%b exp s=0 co=1 gp=1 zero=1",
                     s, co, gp, zero);
        end
    endtask

    task automatic test_overflow();
        a = 4'h7; b = 4'h1; ci = 1'b0; #1;
        checks++;
        if ({s, co, ovf} !== {4'h8, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL ovf_pos got s=%h co=%b ovf=%b exp s=8 co=0 ovf=1", s, co, ovf);
        end
        a = 4'h8; b = 4'h8; ci = 1'b0; #1;
        checks++;
        if ({s, co, ovf} !== {4'h0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL ovf_neg got s=%h co=%b ovf=%b exp s=0 co=1 ovf=1", s, co, ovf);
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        drive(4'h3, 4'h4, 1'b1, 1'b0, 1'b1);
        tick();
        @(negedge clk);
        tick();
        @(negedge clk);
        drive(4'h3, 4'h4, 1'b1, 1'b1, 1'b0);
        tick();
        checks++;
        if ({s_q, vld_q} !== {4'h8, 1'b1}) begin
            failures++;
            $display("FAIL reg_capture got s_q=%h vld_q=%b exp s_q=8 vld_q=1", s_q, vld_q);
        end
        @(negedge clk);
        drive(4'h1, 4'h1, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if ({s_q, vld_q} !== {4'h8, 1'b0}) begin
            failures++;
            $display("FAIL reg_hold got s_q=%h vld_q=%b exp s_q=8 vld_q=0", s_q, vld_q);
        end
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        drive(4'h9, 4'h9, 1'b1, 1'b1, 1'b0);
        tick();
        @(negedge clk);
        drive(4'h6, 4'h7, 1'b0, 1'b1, 1'b1);
        tick();
        checks++;
        if ({s_q, co_q, vld_q} !== {4'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL rst_prio_regs got s_q=%h co_q=%b vld_q=%b exp 0 0 0",
                     s_q, co_q, vld_q);
        end
        checks++;
        if (s !== 4'hD) begin
            failures++;
            $display("FAIL rst_prio_comb got s=%h exp=%h", s, 4'hD);
        end
        @(negedge clk);
        drive(4'h2, 4'h2, 1'b0, 1'b1, 1'b0);
        tick();
        checks++;
        if ({s_q, vld_q} !== {4'h4, 1'b1}) begin
            failures++;
            $display("FAIL rst_resume got s_q=%h vld_q=%b exp s_q=4 vld_q=1", s_q, vld_q);
        end
    endtask

    task automatic test_random_registered();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            drive(4'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0));
            tick();
            checks++;
            if ({s_q, co_q, ovf_q, vld_q} !== {m_s_q, m_co_q, m_ovf_q, m_vld_q}) begin
                failures++;
                $display("FAIL random_reg n=%0d got=%b exp=%b", n,
                         {s_q, co_q, ovf_q, vld_q}, {m_s_q, m_co_q, m_ovf_q, m_vld_q});
            end
        end
    endtask

    initial begin
        m_s_q = 4'h0; m_co_q = 1'b0; m_ovf_q = 1'b0; m_vld_q = 1'b0;
        drive(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        test_reset();
        test_exhaustive();
        test_boundary();
        test_overflow();
        test_registered();
        test_reset_priority();
        test_random_registered();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
